// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a pending-write
// scoreboard, hardwired zero register and write collision flag.
//
// Ports:
//   clk, rst_n    clock (rising edge), async active-low reset
//   wr_en        per-port write enable (higher index = higher priority)
//   wr_addr      packed write addresses, port i at [i*ADDR_W +: ADDR_W]
//   wr_data      packed write data, port i at [i*DATA_W +: DATA_W]
//   rd_addr      packed read addresses
//   rd_data      packed read data (combinational)
//   rd_busy      per-read-port pending flag (combinational)
//   busy_set     mark busy_addr as pending
//   busy_addr    scoreboard set address
//   wr_collision previous cycle had >=2 enabled writes to one nonzero address
module regfile_mp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 3,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_addr,
    output logic                     wr_collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              coll_q;
    logic              coll_d;

    // Per-address winning write; later (higher) ports override earlier ones.
    logic [DEPTH-1:0]  wen;
    logic [DATA_W-1:0] wdat [DEPTH];

    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            wen[a]  = 1'b0;
            wdat[a] = '0;
        end
        for (int i = 0; i < NUM_WR; i++) begin
            for (int a = 1; a < DEPTH; a++) begin
                if (wr_en[i] && wr_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(a)) begin
                    wen[a]  = 1'b1;
                    wdat[a] = wr_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        coll_d = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_en[i] && wr_en[j]
                    && wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W]
                    && wr_addr[i*ADDR_W +: ADDR_W] != '0)
                    coll_d = 1'b1;
            end
        end
    end

    // Set has priority over a clearing write to the same register.
    always_comb begin
        busy_d = busy_q & ~wen;
        if (busy_set && busy_addr != '0)
            busy_d[busy_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] ra;
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            if (ra != '0) begin
                if (BYPASS != 0 && wen[ra]) begin
                    rd_data[k*DATA_W +: DATA_W] = wdat[ra];
                    rd_busy[k] = 1'b0;
                end else begin
                    rd_data[k*DATA_W +: DATA_W] = regs_q[ra];
                    rd_busy[k] = busy_q[ra];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++)
                regs_q[a] <= '0;
            busy_q <= '0;
            coll_q <= 1'b0;
        end else begin
            for (int a = 1; a < DEPTH; a++) begin
                if (wen[a])
                    regs_q[a] <= wdat[a];
            end
            busy_q <= busy_d;
            coll_q <= coll_d;
        end
    end

    assign wr_collision = coll_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp with and without bypass.
// Two instances share stimulus; b1 has BYPASS=1, b0 has BYPASS=0.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [2:0]  wr_en;
    logic [11:0] wr_addr;
    logic [23:0] wr_data;
    logic [7:0]  rd_addr;
    logic        busy_set;
    logic [3:0]  busy_addr;
    logic [15:0] rd_data1, rd_data0;
    logic [1:0]  rd_busy1, rd_busy0;
    logic        coll1, coll0;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_mp #(.BYPASS(1)) b1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .wr_collision(coll1)
    );

    regfile_mp #(.BYPASS(0)) b0 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .wr_collision(coll0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wr_en    = '0;
        busy_set = 1'b0;
    endtask

    task automatic wr(input int p, input logic [3:0] a, input logic [7:0] d);
        wr_en[p]          = 1'b1;
        wr_addr[p*4 +: 4] = a;
        wr_data[p*8 +: 8] = d;
    endtask

    task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
        busy_set  = 1'b0;
        busy_addr = '0;
        rd(4'd3, 4'd0);
        #2;
        chk("rst_rd_b1", 16'(rd_data1), 16'h0000);
        chk("rst_busy_b1", 16'(rd_busy1), 16'h0);
        chk("rst_coll_b1", 16'(coll1), 16'h0);
        chk("rst_coll_b0", 16'(coll0), 16'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // r3 <= A5 via port 0, write to r0 is discarded
        wr(0, 4'd3, 8'hA5);
        wr(1, 4'd0, 8'hFF);
        rd(4'd3, 4'd0);
        #1;
        chk("byp_r3_b1", 16'(rd_data1[7:0]), 16'hA5);
        chk("nobyp_r3_b0", 16'(rd_data0[7:0]), 16'h00);
        chk("byp_r0_b1", 16'(rd_data1[15:8]), 16'h00);
        tick();
        clr();
        #1;
        chk("r3_b1", 16'(rd_data1[7:0]), 16'hA5);
        chk("r3_b0", 16'(rd_data0[7:0]), 16'hA5);
        chk("r0_b1", 16'(rd_data1[15:8]), 16'h00);
        chk("r0_b0", 16'(rd_data0[15:8]), 16'h00);
        chk("nocoll_b1", 16'(coll1), 16'h0);

        // three-way collision on r5, port 2 wins
        wr(0, 4'd5, 8'h11);
        wr(1, 4'd5, 8'h22);
        wr(2, 4'd5, 8'h33);
        rd(4'd5, 4'd0);
        #1;
        chk("coll_byp_b1", 16'(rd_data1[7:0]), 16'h33);
        chk("coll_byp_b0", 16'(rd_data0[7:0]), 16'h00);
        chk("coll_same_cyc", 16'(coll1), 16'h0);
        tick();
        clr();
        #1;
        chk("coll_b1", 16'(coll1), 16'h1);
        chk("coll_b0", 16'(coll0), 16'h1);
        chk("r5_b1", 16'(rd_data1[7:0]), 16'h33);
        chk("r5_b0", 16'(rd_data0[7:0]), 16'h33);
        tick();
        chk("coll_drop_b1", 16'(coll1), 16'h0);
        chk("coll_drop_b0", 16'(coll0), 16'h0);

        // two ports on r0 is not a collision; two ports on different regs neither
        wr(0, 4'd0, 8'h01);
        wr(1, 4'd0, 8'h02);
        tick();
        clr();
        #1;
        chk("coll_r0", 16'(coll1), 16'h0);
        wr(0, 4'd8, 8'h01);
        wr(2, 4'd9, 8'h02);
        tick();
        clr();
        #1;
        chk("coll_diff", 16'(coll1), 16'h0);

        // r7 old value 10, then port 1 writes 5C
        wr(0, 4'd7, 8'h10);
        tick();
        clr();
        wr(1, 4'd7, 8'h5C);
        rd(4'd0, 4'd7);
        #1;
        chk("r7_byp_b1", 16'(rd_data1[15:8]), 16'h5C);
        chk("r7_old_b0", 16'(rd_data0[15:8]), 16'h10);
        tick();
        clr();
        #1;
        chk("r7_new_b0", 16'(rd_data0[15:8]), 16'h5C);
        chk("r7_new_b1", 16'(rd_data1[15:8]), 16'h5C);

        // scoreboard on r4
        busy_set  = 1'b1;
        busy_addr = 4'd4;
        rd(4'd4, 4'd0);
        #1;
        chk("busy_pre_b1", 16'(rd_busy1), 16'h0);
        tick();
        clr();
        #1;
        chk("busy_set_b1", 16'(rd_busy1), 16'h1);
        chk("busy_set_b0", 16'(rd_busy0), 16'h1);
        wr(2, 4'd4, 8'h77);
        #1;
        chk("busy_clr_byp_b1", 16'(rd_busy1), 16'h0);
        chk("busy_hold_b0", 16'(rd_busy0), 16'h1);
        chk("r4_byp_b1", 16'(rd_data1[7:0]), 16'h77);
        tick();
        clr();
        #1;
        chk("busy_after_b1", 16'(rd_busy1), 16'h0);
        chk("busy_after_b0", 16'(rd_busy0), 16'h0);
        chk("r4_b0", 16'(rd_data0[7:0]), 16'h77);
        tick();
        chk("busy_stays_b1", 16'(rd_busy1), 16'h0);

        // busy_set to r0 ignored
        busy_set  = 1'b1;
        busy_addr = 4'd0;
        rd(4'd0, 4'd0);
        tick();
        clr();
        #1;
        chk("busy_r0", 16'(rd_busy1), 16'h0);

        // set and write r6 in the same cycle: set wins, data written
        busy_set  = 1'b1;
        busy_addr = 4'd6;
        wr(1, 4'd6, 8'h66);
        rd(4'd0, 4'd6);
        tick();
        clr();
        #1;
        chk("r6_busy_b1", 16'(rd_busy1), 16'h2);
        chk("r6_busy_b0", 16'(rd_busy0), 16'h2);
        chk("r6_data_b1", 16'(rd_data1[15:8]), 16'h66);
        chk("r6_data_b0", 16'(rd_data0[15:8]), 16'h66);

        // fill r1..r15, then colliding write on r9 plus busy on r2
        for (int i = 1; i < 16; i++) begin
            clr();
            wr(i % 3, 4'(i), {4'(i), 4'(i)});
            tick();
        end
        clr();
        wr(0, 4'd9, 8'hAA);
        wr(2, 4'd9, 8'hBB);
        busy_set  = 1'b1;
        busy_addr = 4'd2;
        tick();
        clr();
        rd(4'd2, 4'd9);
        #1;
        chk("fill_r2", 16'(rd_data1[7:0]), 16'h22);
        chk("fill_r9", 16'(rd_data0[15:8]), 16'hBB);
        chk("fill_busy", 16'(rd_busy1), 16'h1);
        chk("fill_coll", 16'(coll0), 16'h1);
        rd(4'd15, 4'd2);
        #1;
        chk("fill_r15_r2", rd_data1, 16'h22FF);

        // mid-cycle reset
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_rd_b1", rd_data1, 16'h0000);
        chk("mrst_rd_b0", rd_data0, 16'h0000);
        chk("mrst_busy_b1", 16'(rd_busy1), 16'h0);
        chk("mrst_busy_b0", 16'(rd_busy0), 16'h0);
        chk("mrst_coll_b1", 16'(coll1), 16'h0);
        chk("mrst_coll_b0", 16'(coll0), 16'h0);

        // during reset only bypassed data is visible; writes are ignored
        wr(0, 4'd3, 8'h3C);
        busy_set  = 1'b1;
        busy_addr = 4'd3;
        rd(4'd3, 4'd0);
        #1;
        chk("rst_byp_b1", 16'(rd_data1[7:0]), 16'h3C);
        chk("rst_byp_b0", 16'(rd_data0[7:0]), 16'h00);
        tick();
        clr();
        rst_n = 1'b1;
        #1;
        chk("rst_wr_ign", 16'(rd_data1[7:0]), 16'h00);
        chk("rst_busy_ign", 16'(rd_busy1), 16'h0);
        tick();
        chk("post_rst_r3", 16'(rd_data0[7:0]), 16'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
